// File: rtl/reg_file_2r1w.sv
// 2-read/1-write register file, reg 0 reads zero; reads are combinational, writes land on the next clk edge, never stalls.
// Optional macro REGFILE_BYPASS_EN forwards wdata to a same-cycle read of the written register.
module reg_file_2r1w #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr_a,
  output logic [WIDTH-1:0] rdata_a,
  input  logic [AW-1:0]    raddr_b,
  output logic [WIDTH-1:0] rdata_b,
  output logic             wr_err
);

  localparam int NSLOT = 1 << AW;

  logic [WIDTH-1:0] w_mem [NSLOT];
  logic             w_wa_ok;
  logic             w_wr_hit;
  logic             r_wr_err;

  generate
    if (NSLOT == DEPTH) begin : g_wa_full
      assign w_wa_ok = 1'b1;
    end else begin : g_wa_part
      assign w_wa_ok = (waddr < AW'(DEPTH));
    end
  endgenerate

  assign w_wr_hit = we && (waddr != '0) && w_wa_ok;

  // Slot 0 and slots past DEPTH are tied to zero so any such read returns 0.
  generate
    for (genvar i = 0; i < NSLOT; i++) begin : g_reg
      if (i == 0 || i >= DEPTH) begin : g_zero
        assign w_mem[i] = '0;
      end else begin : g_flop
        logic [WIDTH-1:0] r_q;
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            r_q <= '0;
          end else if (w_wr_hit && (waddr == AW'(i))) begin
            r_q <= wdata;
          end
        end
        assign w_mem[i] = r_q;
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_err <= 1'b0;
    end else begin
      r_wr_err <= we && !w_wa_ok;
    end
  end

  assign wr_err = r_wr_err;

`ifdef REGFILE_BYPASS_EN
  // Forwarding is gated by rst_n so reads show zeros while reset is held.
  assign rdata_a = (rst_n && w_wr_hit && (raddr_a == waddr)) ? wdata : w_mem[raddr_a];
  assign rdata_b = (rst_n && w_wr_hit && (raddr_b == waddr)) ? wdata : w_mem[raddr_b];
`else
  assign rdata_a = w_mem[raddr_a];
  assign rdata_b = w_mem[raddr_b];
`endif

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Bench: directed checks on a WIDTH=32/DEPTH=20 instance, random dual-read traffic on a WIDTH=16/DEPTH=8 instance.
module tb_reg_file_2r1w;

  logic clk = 1'b0;
  always #50 clk = ~clk;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  // Instance 1: directed
  logic        rst1_n, we1, err1;
  logic [4:0]  wa1, ra1a, ra1b;
  logic [31:0] wd1, rd1a, rd1b;

  reg_file_2r1w #(.WIDTH(32), .DEPTH(20), .AW(5)) u_dut1 (
    .clk(clk), .rst_n(rst1_n), .we(we1), .waddr(wa1), .wdata(wd1),
    .raddr_a(ra1a), .rdata_a(rd1a), .raddr_b(ra1b), .rdata_b(rd1b), .wr_err(err1)
  );

  // Instance 2: random
  logic        rst2_n, we2, err2;
  logic [3:0]  wa2, ra2a, ra2b;
  logic [15:0] wd2, rd2a, rd2b;

  reg_file_2r1w #(.WIDTH(16), .DEPTH(8), .AW(4)) u_dut2 (
    .clk(clk), .rst_n(rst2_n), .we(we2), .waddr(wa2), .wdata(wd2),
    .raddr_a(ra2a), .rdata_a(rd2a), .raddr_b(ra2b), .rdata_b(rd2b), .wr_err(err2)
  );

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_t;

  sb_t         sb_q[$];
  int          n_chk = 0;
  int          n_err = 0;
  logic [31:0] m1 [32];
  logic [15:0] m2 [16];
  logic        exp_err1 = 1'b0;
  logic        exp_err2 = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] exp);
    sb_t e;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic sb_pop(input logic [31:0] got);
    sb_t e;
    if (sb_q.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      check(e.tag, got, e.exp);
    end
  endtask

  function automatic logic [31:0] m1_rd(input logic [4:0] ra, input logic w,
                                        input logic [4:0] wa, input logic [31:0] wd);
    if (ra == 5'd0 || ra >= 5'd20) return 32'd0;
    if (BYP && w && wa == ra) return wd;
    return m1[ra];
  endfunction

  function automatic logic [15:0] m2_rd(input logic [3:0] ra, input logic w,
                                        input logic [3:0] wa, input logic [15:0] wd);
    if (ra == 4'd0 || ra >= 4'd8) return 16'd0;
    if (BYP && w && wa == ra) return wd;
    return m2[ra];
  endfunction

  // One clock of traffic on instance 1; returns at the negedge with inputs still applied.
  task automatic d1_cycle(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                          input logic [4:0] ra, input logic [4:0] rb);
    @(posedge clk);
    #1;
    we1 = w; wa1 = wa; wd1 = wd; ra1a = ra; ra1b = rb;
    sb_push("d1_rd_a", m1_rd(ra, w, wa, wd));
    sb_push("d1_rd_b", m1_rd(rb, w, wa, wd));
    sb_push("d1_wr_err", {31'd0, exp_err1});
    @(negedge clk);
    sb_pop(rd1a);
    sb_pop(rd1b);
    sb_pop({31'd0, err1});
    if (w && wa != 5'd0 && wa < 5'd20) m1[wa] = wd;
    exp_err1 = w && (wa >= 5'd20);
  endtask

  initial begin
    logic       w;
    logic [3:0] wa, ra, rb;
    logic [15:0] wd;

    for (int i = 0; i < 32; i++) m1[i] = 32'd0;
    for (int i = 0; i < 16; i++) m2[i] = 16'd0;
    rst1_n = 1'b0; rst2_n = 1'b0;
    we1 = 1'b0; wa1 = 5'd0; wd1 = 32'd0; ra1a = 5'd5; ra1b = 5'd19;
    we2 = 1'b0; wa2 = 4'd0; wd2 = 16'd0; ra2a = 4'd1; ra2b = 4'd7;
    #10;
    check("rst_rd_a", rd1a, 32'd0);
    check("rst_rd_b", rd1b, 32'd0);
    check("rst_wr_err", {31'd0, err1}, 32'd0);
    check("rst2_rd_a", {16'd0, rd2a}, 32'd0);
    #20;
    rst1_n = 1'b1; rst2_n = 1'b1;

    // Basic write then dual read of the same register
    d1_cycle(1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0);
    d1_cycle(1'b0, 5'd0, 32'd0, 5'd5, 5'd5);
    check("r5_port_a", rd1a, 32'hDEADBEEF);
    check("r5_port_b", rd1b, 32'hDEADBEEF);

    // Writes to reg 0 are dropped without an error
    d1_cycle(1'b1, 5'd0, 32'h12345678, 5'd0, 5'd5);
    d1_cycle(1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    check("r0_zero", rd1a, 32'd0);
    check("r0_no_err", {31'd0, err1}, 32'd0);

    // Out-of-range write: one-cycle error, nothing stored
    d1_cycle(1'b1, 5'd25, 32'hFFFFFFFF, 5'd25, 5'd5);
    d1_cycle(1'b0, 5'd0, 32'd0, 5'd25, 5'd19);
    check("oor_err_set", {31'd0, err1}, 32'd1);
    check("oor_rd_zero", rd1a, 32'd0);
    d1_cycle(1'b0, 5'd0, 32'd0, 5'd5, 5'd1);
    check("oor_err_clr", {31'd0, err1}, 32'd0);
    check("oor_r5_kept", rd1a, 32'hDEADBEEF);

    // we=0 must not change anything
    d1_cycle(1'b0, 5'd5, 32'hCAFEF00D, 5'd5, 5'd5);
    d1_cycle(1'b0, 5'd0, 32'd0, 5'd5, 5'd0);
    check("we0_hold", rd1a, 32'hDEADBEEF);

    // Same-cycle read of the register being written
    d1_cycle(1'b1, 5'd7, 32'h11, 5'd0, 5'd0);
    d1_cycle(1'b1, 5'd7, 32'h22, 5'd7, 5'd7);
    check("rw_same_cycle", rd1a, BYP ? 32'h22 : 32'h11);
    d1_cycle(1'b0, 5'd0, 32'd0, 5'd7, 5'd0);
    check("rw_next_cycle", rd1a, 32'h22);

    // Fill regs 1..31 with their index, then reset asynchronously mid-cycle
    for (int i = 1; i < 32; i++) d1_cycle(1'b1, 5'(i), 32'(i), 5'(i - 1), 5'(32 - i));
    d1_cycle(1'b0, 5'd0, 32'd0, 5'd13, 5'd19);
    @(posedge clk);
    #2;
    we1 = 1'b0;
    rst1_n = 1'b0;
    for (int a = 0; a < 20; a++) begin
      ra1a = 5'(a);
      ra1b = 5'(19 - a);
      #1;
      sb_push("arst_rd_a", 32'd0);
      sb_push("arst_rd_b", 32'd0);
      sb_pop(rd1a);
      sb_pop(rd1b);
      #1;
    end
    check("arst_wr_err", {31'd0, err1}, 32'd0);
    for (int i = 0; i < 32; i++) m1[i] = 32'd0;
    exp_err1 = 1'b0;

    // A write edge during reset is ignored
    we1 = 1'b1; wa1 = 5'd3; wd1 = 32'hAAAA5555; ra1a = 5'd3;
    @(posedge clk);
    #1;
    check("wr_in_rst", rd1a, 32'd0);
    @(negedge clk);
    we1 = 1'b0;
    rst1_n = 1'b1;

    // First write after reset release lands normally
    d1_cycle(1'b1, 5'd3, 32'h55, 5'd3, 5'd0);
    d1_cycle(1'b0, 5'd0, 32'd0, 5'd3, 5'd3);
    check("post_rst_wr", rd1b, 32'h55);

    // Random traffic against the reference model
    for (int c = 0; c < 10000; c++) begin
      @(posedge clk);
      #1;
      w  = 1'($urandom_range(0, 1));
      wa = 4'($urandom_range(0, 15));
      wd = 16'($urandom);
      ra = ($urandom_range(0, 3) == 0) ? wa : 4'($urandom_range(0, 15));
      rb = ($urandom_range(0, 3) == 0) ? ra : 4'($urandom_range(0, 15));
      we2 = w; wa2 = wa; wd2 = wd; ra2a = ra; ra2b = rb;
      sb_push("d2_rd_a", {16'd0, m2_rd(ra, w, wa, wd)});
      sb_push("d2_rd_b", {16'd0, m2_rd(rb, w, wa, wd)});
      sb_push("d2_wr_err", {31'd0, exp_err2});
      @(negedge clk);
      sb_pop({16'd0, rd2a});
      sb_pop({16'd0, rd2b});
      sb_pop({31'd0, err2});
      if (w && wa != 4'd0 && wa < 4'd8) m2[wa] = wd;
      exp_err2 = w && (wa >= 4'd8);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/reg_file_2r1w.md
REG_FILE_2R1W -- requirements
Module: reg_file_2r1w

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the register data width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 32, giving the register count (2..1024, need not be a power of two).
REQ-003 The block SHALL have parameter AW, default 5, giving the address width; AW SHALL satisfy 2^AW >= DEPTH.
REQ-004 The block SHALL have port clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port we, input, 1 bit: write enable.
REQ-007 The block SHALL have port waddr, input, AW bits: write address.
REQ-008 The block SHALL have port wdata, input, WIDTH bits: write data.
REQ-009 The block SHALL have port raddr_a, input, AW bits: read port A address.
REQ-010 The block SHALL have port rdata_a, output, WIDTH bits: read port A data.
REQ-011 The block SHALL have port raddr_b, input, AW bits: read port B address.
REQ-012 The block SHALL have port rdata_b, output, WIDTH bits: read port B data.
REQ-013 The block SHALL have port wr_err, output, 1 bit: registered flag for an out-of-range write attempt.

Function
REQ-014 Storage SHALL be DEPTH registers of WIDTH bits; register 0 is hardwired to zero.
REQ-015 On a clk rising edge with we=1 and 0 < waddr < DEPTH, register[waddr] SHALL load wdata.
REQ-016 A write with waddr=0 SHALL be silently discarded; wr_err is not set.
REQ-017 A write with waddr >= DEPTH SHALL be discarded, and wr_err SHALL be 1 for exactly the following cycle.
REQ-018 wr_err SHALL be 0 in every cycle not covered by REQ-017.
REQ-019 Reads SHALL be combinational, with zero cycles of latency: rdata_x = register[raddr_x] whenever raddr_x < DEPTH.
REQ-020 A read with raddr_x = 0 or raddr_x >= DEPTH SHALL return all zeros.
REQ-021 Ports A and B SHALL be fully independent; both may address the same register, and both SHALL return identical data.
REQ-022 A same-cycle read of the register being written SHALL return data as defined in REQ-027/REQ-028.
REQ-023 When we=0, no register SHALL change, regardless of waddr or wdata.

Reset
REQ-024 While rst_n=0, all registers SHALL clear to 0 asynchronously, without waiting for a clk edge, and wr_err SHALL be 0.
REQ-025 A write edge coinciding with rst_n=0 SHALL be ignored; the register stays 0.
REQ-026 After rst_n deasserts, the first clk rising edge with we=1 SHALL write normally.

Configuration
REQ-027 With macro REGFILE_BYPASS_EN defined, when we=1, 0 < waddr < DEPTH and raddr_x = waddr, rdata_x SHALL equal wdata in that same cycle (write-to-read forwarding).
REQ-028 Without REGFILE_BYPASS_EN, rdata_x SHALL show the pre-write register contents during the write cycle, and the new value from the cycle after.
REQ-029 Forwarding SHALL never apply to address 0 or to out-of-range addresses, whether the macro is defined or not.

Verification
REQ-030 Reset, then write 0xDEADBEEF to reg 5; read A=5 and B=5 next cycle -> both ports return 0xDEADBEEF.
REQ-031 Write 0x12345678 to reg 0, then read A=0 -> returns 0x00000000; wr_err stays 0.
REQ-032 With DEPTH=20, write 0xFFFFFFFF to addr 25 -> wr_err=1 for one cycle; a read of addr 25 returns 0; no register changes.
REQ-033 Reg 7=0x11; in the same cycle write 0x22 to reg 7 and read A=7 -> returns 0x22 with REGFILE_BYPASS_EN, 0x11 without; the next cycle returns 0x22 either way.
REQ-034 Fill regs 1..31 with index values, then drop rst_n mid-cycle, between clock edges -> all reads return 0 immediately, before the next clk edge.
REQ-035 Run random concurrent writes and dual reads for 10k cycles with WIDTH=16, DEPTH=8 -> outputs match a reference model on every cycle.
